// File: rtl/cmos_frame_gate_pkg.sv
// Shared video package: capture-gate state encoding and default frame geometry,
// also used by the VGA display stage so both ends agree on the frame size.
package cmos_frame_gate_pkg;

  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES  = 480;
  localparam int CNT_W        = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    DROP    = 2'd3
  } gate_state_t;

  // Where a frame goes once vsync falls: keep capturing only if still enabled.
  function automatic gate_state_t after_frame(input logic capture_en);
    return capture_en ? WAIT_VS : IDLE;
  endfunction

endpackage

// File: rtl/cmos_frame_gate_edge_det.sv
// Registered rise/fall detector for one sync input in the pixel clock domain.
module cmos_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  // Remember last cycle's level so edges show up in the cycle the new level is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/cmos_frame_gate.sv
// Frame gate between the CMOS capture stage and the SDRAM write FIFO: only
// whole frames of exact geometry are passed; malformed frames are dropped.
module cmos_frame_gate
  import cmos_frame_gate_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        in_vsync,
  input  logic        in_href,
  input  logic        in_clken,
  input  logic [15:0] in_data,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_abort,
  output logic        err_line_len,
  output logic        err_line_cnt,
  output logic [7:0]  frame_cnt
);

  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_PIXELS);
  localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_LINES);

  gate_state_t      state, state_next;
  logic [CNT_W-1:0] pix_cnt, pix_next;
  logic [CNT_W-1:0] line_cnt, line_next, line_upd;
  logic             line_ok;
  logic             first_pending, first_next;
  logic             wr_en_next, start_next, done_next, abort_next;
  logic             len_err_set, cnt_err_set, cnt_inc;
  logic             vs_rise, vs_fall, hr_rise, hr_fall;

  cmos_edge_det u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (in_vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  cmos_edge_det u_hr_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (in_href),
    .rise (hr_rise),
    .fall (hr_fall)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, counters and output strobes; line check precedes the frame check.
  always_comb begin
    state_next  = state;
    pix_next    = pix_cnt;
    line_next   = line_cnt;
    line_upd    = line_cnt;
    line_ok     = 1'b1;
    first_next  = first_pending;
    wr_en_next  = 1'b0;
    start_next  = 1'b0;
    done_next   = 1'b0;
    abort_next  = 1'b0;
    len_err_set = 1'b0;
    cnt_err_set = 1'b0;
    cnt_inc     = 1'b0;

    case (state)
      IDLE: begin
        pix_next   = '0;
        line_next  = '0;
        first_next = 1'b0;
        if (capture_en && !in_vsync) state_next = WAIT_VS;
      end

      WAIT_VS: begin
        pix_next  = '0;
        line_next = '0;
        if (vs_rise) begin
          state_next = ACTIVE;
          first_next = 1'b1;
        end
      end

      ACTIVE: begin
        if (hr_fall) begin
          pix_next = '0;
          if (pix_cnt == H_MAX) line_upd = line_cnt + 1'b1;
          else                  line_ok  = 1'b0;
        end
        line_next = line_upd;

        if (vs_fall) begin
          state_next = after_frame(capture_en);
          pix_next   = '0;
          line_next  = '0;
          first_next = 1'b0;
          if (!line_ok) begin
            len_err_set = 1'b1;
            abort_next  = 1'b1;
          end else if (line_upd == V_MAX) begin
            done_next = 1'b1;
            cnt_inc   = 1'b1;
          end else begin
            cnt_err_set = 1'b1;
            abort_next  = 1'b1;
          end
        end else if (!line_ok) begin
          len_err_set = 1'b1;
          abort_next  = 1'b1;
          state_next  = DROP;
          pix_next    = '0;
          line_next   = '0;
          first_next  = 1'b0;
        end else if (in_clken && in_href) begin
          if (pix_cnt == H_MAX) begin
            len_err_set = 1'b1;
            abort_next  = 1'b1;
            state_next  = DROP;
            pix_next    = '0;
            line_next   = '0;
            first_next  = 1'b0;
          end else if (line_cnt == V_MAX) begin
            cnt_err_set = 1'b1;
            abort_next  = 1'b1;
            state_next  = DROP;
            pix_next    = '0;
            line_next   = '0;
            first_next  = 1'b0;
          end else begin
            wr_en_next = 1'b1;
            pix_next   = pix_cnt + 1'b1;
            start_next = first_pending;
            first_next = 1'b0;
          end
        end
      end

      DROP: begin
        pix_next   = '0;
        line_next  = '0;
        first_next = 1'b0;
        if (vs_fall) state_next = after_frame(capture_en);
      end

      default: begin
        state_next = IDLE;
        pix_next   = '0;
        line_next  = '0;
        first_next = 1'b0;
      end
    endcase
  end

  // Registered outputs, counters and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt       <= '0;
      line_cnt      <= '0;
      first_pending <= 1'b0;
      wr_en         <= 1'b0;
      wr_data       <= '0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      frame_abort   <= 1'b0;
      err_line_len  <= 1'b0;
      err_line_cnt  <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      pix_cnt       <= pix_next;
      line_cnt      <= line_next;
      first_pending <= first_next;
      wr_en         <= wr_en_next;
      if (wr_en_next) wr_data <= in_data;
      frame_start   <= start_next;
      frame_done    <= done_next;
      frame_abort   <= abort_next;
      err_line_len  <= err_line_len | len_err_set;
      err_line_cnt  <= err_line_cnt | cnt_err_set;
      if (cnt_inc) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // href rise is not needed for gating; the line is delimited by its falling edge.
  logic unused_ok;
  assign unused_ok = hr_rise;

endmodule

// File: tb/tb_cmos_frame_gate.sv
// Directed bench for cmos_frame_gate using a small frame geometry; expected
// pixels go into a scoreboard queue as they are driven and are checked on write.
module tb_cmos_frame_gate;
  import cmos_frame_gate_pkg::*;

  localparam int H = 8;
  localparam int V = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture_en = 1'b0;
  logic        in_vsync = 1'b0;
  logic        in_href = 1'b0;
  logic        in_clken = 1'b0;
  logic [15:0] in_data = '0;
  logic        wr_en, frame_start, frame_done, frame_abort;
  logic        err_line_len, err_line_cnt;
  logic [15:0] wr_data;
  logic [7:0]  frame_cnt;

  typedef struct {
    logic [15:0] data;
    int          cyc;
    bit          first;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   writes = 0, start_n = 0, done_n = 0, abort_n = 0;
  int   last_abort_cyc = -1;
  int   snap_writes = 0, snap_start = 0, snap_done = 0, snap_abort = 0;

  cmos_frame_gate #(.H_PIXELS(H), .V_LINES(V)) dut (
    .clk          (clk),
    .rst          (rst),
    .capture_en   (capture_en),
    .in_vsync     (in_vsync),
    .in_href      (in_href),
    .in_clken     (in_clken),
    .in_data      (in_data),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .err_line_len (err_line_len),
    .err_line_cnt (err_line_cnt),
    .frame_cnt    (frame_cnt)
  );

  // 10 ns pixel clock.
  always #5 clk = ~clk;

  // Cycle index used to time-stamp stimulus and measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor on the falling edge: pop the scoreboard on every write and tally pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        writes++;
        checkOutput("wr_expected", logic'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("wr_data", wr_data, e.data);
          checkOutput("wr_latency", cyc - e.cyc, 1);
          checkOutput("frame_start_pos", frame_start, e.first);
        end
      end
      if (frame_start) begin
        start_n++;
        checkOutput("start_has_wr", wr_en, 1);
      end
      if (frame_done) done_n++;
      if (frame_abort) begin
        abort_n++;
        last_abort_cyc = cyc;
      end
      if (frame_start || frame_done || frame_abort)
        checkOutput("pulse_excl", 32'(frame_start) + 32'(frame_done) + 32'(frame_abort), 1);
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_en"}, wr_en, 0);
    checkOutput({tag, "_wr_data"}, wr_data, 0);
    checkOutput({tag, "_pulses"}, {frame_start, frame_done, frame_abort}, 0);
    checkOutput({tag, "_errs"}, {err_line_len, err_line_cnt}, 0);
    checkOutput({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  // One frame: optional short line, enable/disable at a line, reset mid-line,
  // and href/vsync falling together on the last line.
  task automatic applyStimulus(input int n_lines, input int short_idx, input bit accept,
                               input int en_line, input int dis_line, input int rst_line,
                               input bit tight_end, output int exp_abort);
    bit writing;
    bit first;
    int len;
    writing   = accept;
    first     = 1'b1;
    exp_abort = -1;
    in_vsync = 1'b0; in_href = 1'b0; in_clken = 1'b0;
    repeat (4) step();
    in_vsync = 1'b1;
    repeat (3) step();
    for (int l = 0; l < n_lines; l++) begin
      if (l == en_line)  capture_en = 1'b1;
      if (l == dis_line) capture_en = 1'b0;
      len = (l == short_idx) ? H - 1 : H;
      for (int p = 0; p < len; p++) begin
        in_href = 1'b1; in_clken = 1'b0;
        step();
        if (l == rst_line && p == H / 2) begin
          rst = 1'b1;
          #1;
          checkResetOutputs("mid_rst");
          step();
          step();
          rst = 1'b0;
          writing = 1'b0;
        end
        in_clken = 1'b1;
        in_data  = 16'($urandom);
        if (l >= V && writing) begin
          exp_abort = cyc;
          writing   = 1'b0;
        end
        if (writing) begin
          sb.push_back('{data: in_data, cyc: cyc, first: first});
          first = 1'b0;
        end
        step();
      end
      in_clken = 1'b0;
      in_href  = 1'b0;
      if (tight_end && l == n_lines - 1) begin
        in_vsync = 1'b0;
        step();
      end else begin
        if (l == short_idx && writing) begin
          exp_abort = cyc;
          writing   = 1'b0;
        end
        repeat (3) step();
      end
    end
    if (!tight_end) begin
      if (writing && n_lines < V) exp_abort = cyc;
      in_vsync = 1'b0;
    end
    repeat (4) step();
  endtask

  task automatic checkFrame(input string tag, input int exp_wr, input int exp_start, input int exp_done,
                            input int exp_abort_n, input int exp_fcnt, input bit exp_len, input bit exp_cnt);
    checkOutput({tag, "_writes"}, writes - snap_writes, exp_wr);
    checkOutput({tag, "_starts"}, start_n - snap_start, exp_start);
    checkOutput({tag, "_dones"}, done_n - snap_done, exp_done);
    checkOutput({tag, "_aborts"}, abort_n - snap_abort, exp_abort_n);
    checkOutput({tag, "_frame_cnt"}, frame_cnt, exp_fcnt);
    checkOutput({tag, "_err_len"}, err_line_len, exp_len);
    checkOutput({tag, "_err_cnt"}, err_line_cnt, exp_cnt);
    checkOutput({tag, "_sb_empty"}, sb.size(), 0);
    snap_writes = writes;
    snap_start  = start_n;
    snap_done   = done_n;
    snap_abort  = abort_n;
  endtask

  initial begin
    int ab;
    #1;
    checkResetOutputs("por");
    repeat (3) step();
    rst = 1'b0;
    step();

    $display("[TB] three good frames");
    capture_en = 1'b1;
    applyStimulus(V, -1, 1, -1, -1, -1, 0, ab);
    applyStimulus(V, -1, 1, -1, -1, -1, 0, ab);
    applyStimulus(V, -1, 1, -1, -1, -1, 1, ab);
    checkFrame("three", 3 * H * V, 3, 3, 0, 3, 0, 0);

    $display("[TB] short line then recovery");
    applyStimulus(V, 2, 1, -1, -1, -1, 0, ab);
    checkOutput("short_abort_cyc", last_abort_cyc, ab + 1);
    checkFrame("short", 2 * H + H - 1, 1, 0, 1, 3, 1, 0);
    applyStimulus(V, -1, 1, -1, -1, -1, 0, ab);
    checkFrame("after_short", H * V, 1, 1, 0, 4, 1, 0);

    $display("[TB] too many and too few lines");
    applyStimulus(V + 1, -1, 1, -1, -1, -1, 0, ab);
    checkOutput("long_abort_cyc", last_abort_cyc, ab + 1);
    checkFrame("long", H * V, 1, 0, 1, 4, 1, 1);
    applyStimulus(V - 1, -1, 1, -1, -1, -1, 0, ab);
    checkOutput("few_abort_cyc", last_abort_cyc, ab + 1);
    checkFrame("few", H * (V - 1), 1, 0, 1, 4, 1, 1);

    $display("[TB] capture disabled mid-frame");
    applyStimulus(V, -1, 1, -1, 3, -1, 0, ab);
    checkFrame("disable", H * V, 1, 1, 0, 5, 1, 1);
    checkOutput("disable_state", dut.state, IDLE);
    applyStimulus(V, -1, 0, -1, -1, -1, 0, ab);
    checkFrame("disabled", 0, 0, 0, 0, 5, 1, 1);

    $display("[TB] enable asserted inside a frame");
    applyStimulus(V, -1, 0, 2, -1, -1, 0, ab);
    checkFrame("en_mid", 0, 0, 0, 0, 5, 1, 1);
    applyStimulus(V, -1, 1, -1, -1, -1, 0, ab);
    checkFrame("en_next", H * V, 1, 1, 0, 6, 1, 1);

    $display("[TB] reset mid-line");
    applyStimulus(V, -1, 1, -1, -1, 2, 0, ab);
    checkFrame("rst_frame", 2 * H + H / 2, 1, 0, 0, 0, 0, 0);
    applyStimulus(V, -1, 1, -1, -1, -1, 0, ab);
    checkFrame("rst_next", H * V, 1, 1, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
